// File: rtl/eq_band_mixer.sv
// Equalizer band mixer: after each sample strobe, waits for the band filters
// to settle, then multiply-accumulates every band output with its snapshot
// gain through one shared multiplier. The Q3.12 result is floored and
// saturated to a 16-bit sample.
module eq_band_mixer #(
    parameter int N_BAND      = 5,
    parameter int WAIT_CYCLES = 10,
    parameter int GAIN_FRAC   = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  new_data,
    input  logic [16*N_BAND-1:0]  band_in,
    input  logic [16*N_BAND-1:0]  gain,
    output logic [15:0]           y_out,
    output logic                  y_valid,
    output logic                  busy,
    output logic                  overrun
);

    // 40 bits holds 8 full-scale 32-bit products with headroom to spare.
    localparam int ACC_W = 40;
    localparam int IDX_W = (N_BAND > 1) ? $clog2(N_BAND) : 1;
    localparam int WC_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

    typedef enum logic [1:0] {IDLE, WAIT, MAC, OUT} state_t;

    state_t                    state_q, state_d;
    logic [WC_W-1:0]           wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]          band_idx_q, band_idx_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [15:0]        gain_q [N_BAND];
    logic signed [15:0]        gain_d [N_BAND];
    logic signed [15:0]        y_out_q, y_out_d;
    logic                      y_valid_q, y_valid_d;
    logic                      overrun_q, overrun_d;

    logic signed [15:0]        band_sel;
    logic signed [15:0]        gain_sel;
    logic signed [31:0]        prod;
    logic signed [ACC_W-1:0]   acc_shift;

    // Clamp a floored accumulator value into the signed 16-bit output range.
    function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return 16'sh7fff;
        end else if (v < SAT_MIN) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

    // Shared multiplier: the band index selects which live band and which gain feed it.
    always_comb begin
        band_sel  = band_in[{band_idx_q, 4'b0000} +: 16];
        gain_sel  = gain_q[band_idx_q];
        prod      = band_sel * gain_sel;
        acc_shift = acc_q >>> GAIN_FRAC;
    end

    // Next-state, counters, accumulator and output updates for the sequencer.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        band_idx_d = band_idx_q;
        acc_d      = acc_q;
        gain_d     = gain_q;
        y_out_d    = y_out_q;
        y_valid_d  = 1'b0;
        overrun_d  = overrun_q | (new_data && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (new_data) begin
                    for (int k = 0; k < N_BAND; k++) begin
                        gain_d[k] = gain[16*k +: 16];
                    end
                    acc_d      = '0;
                    wait_cnt_d = '0;
                    band_idx_d = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q == WC_W'(WAIT_CYCLES - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = MAC;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            MAC: begin
                acc_d = acc_q + {{(ACC_W-32){prod[31]}}, prod};
                if (band_idx_q == IDX_W'(N_BAND - 1)) begin
                    state_d = OUT;
                end else begin
                    band_idx_d = band_idx_q + 1'b1;
                end
            end
            OUT: begin
                y_out_d   = sat16(acc_shift);
                y_valid_d = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any sample in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            band_idx_q <= '0;
            acc_q      <= '0;
            gain_q     <= '{default: '0};
            y_out_q    <= '0;
            y_valid_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            band_idx_q <= band_idx_d;
            acc_q      <= acc_d;
            gain_q     <= gain_d;
            y_out_q    <= y_out_d;
            y_valid_q  <= y_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign y_out   = y_out_q;
    assign y_valid = y_valid_q;
    assign busy    = (state_q != IDLE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Bench for eq_band_mixer: a sample-level reference model predicts each mixed
// output and its due cycle into a scoreboard; a monitor on the falling edge
// checks outputs, busy and overrun against it.
module tb_eq_band_mixer;

    localparam int NB  = 5;
    localparam int WC  = 10;
    localparam int GF  = 12;
    localparam int LAT = WC + NB + 1;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b1;
    logic              new_data = 1'b0;
    logic [16*NB-1:0]  band_in  = '0;
    logic [16*NB-1:0]  gain     = '0;
    logic [15:0]       y_out;
    logic              y_valid;
    logic              busy;
    logic              overrun;

    eq_band_mixer #(.N_BAND(NB), .WAIT_CYCLES(WC), .GAIN_FRAC(GF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .new_data (new_data),
        .band_in  (band_in),
        .gain     (gain),
        .y_out    (y_out),
        .y_valid  (y_valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint word(input logic [16*NB-1:0] v, input int k);
        logic signed [15:0] w;
        w = v[16*k +: 16];
        return longint'(w);
    endfunction

    function automatic logic [16*NB-1:0] put(input logic [16*NB-1:0] v, input int k,
                                             input logic [15:0] w);
        v[16*k +: 16] = w;
        return v;
    endfunction

    // Mixed sample from an exact sum: floor-divide by 2^GF, then clamp.
    function automatic longint mix_out(input longint acc);
        longint s;
        s = acc >>> GF;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int     due;
        longint y;
    } exp_t;

    exp_t   sb[$];
    int     cyc      = 0;
    bit     m_active = 1'b0;
    int     m_t      = 0;
    longint m_acc    = 0;
    longint m_snap [NB];
    bit     m_ovr    = 1'b0;
    longint hold_y   = 0;

    always @(negedge rst_n) begin
        m_active = 1'b0;
        m_ovr    = 1'b0;
        m_acc    = 0;
        hold_y   = 0;
        sb.delete();
    end

    always @(posedge clk) begin
        int k;
        cyc++;
        if (!rst_n) begin
            m_active = 1'b0;
            m_ovr    = 1'b0;
            sb.delete();
        end else if (m_active) begin
            if (new_data) m_ovr = 1'b1;
            k = cyc - m_t - WC - 1;
            if (k >= 0 && k < NB) begin
                m_acc += word(band_in, k) * m_snap[k];
            end else if (cyc == m_t + LAT) begin
                sb.push_back('{due: cyc, y: mix_out(m_acc)});
                m_active = 1'b0;
            end
        end else if (new_data) begin
            m_active = 1'b1;
            m_t      = cyc;
            m_acc    = 0;
            for (int j = 0; j < NB; j++) m_snap[j] = word(gain, j);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            check("y_valid_pulse", longint'(y_valid), 1);
            check("y_out_value", longint'($signed(y_out)), sb[0].y);
            hold_y = sb[0].y;
            void'(sb.pop_front());
        end else begin
            check("y_valid_low", longint'(y_valid), 0);
            check("y_out_hold", longint'($signed(y_out)), hold_y);
        end
        check("busy", longint'(busy), longint'(m_active));
        check("overrun", longint'(overrun), longint'(m_ovr));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        new_data = 1'b1;
        tick();
        new_data = 1'b0;
    endtask

    initial begin
        int cnt;
        #1 rst_n = 1'b0;
        tick();
        check("rst_y_out", longint'(y_out), 0);
        check("rst_y_valid", longint'(y_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_overrun", longint'(overrun), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Unity gain on band 0 only
        gain    = put('0, 0, 16'sd4096);
        band_in = put('0, 0, 16'sd1000);
        pulse();
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            tick();
        end
        check("unity_busy_cycles", cnt, 16);
        check("unity_y_out", longint'($signed(y_out)), 1000);
        check("unity_y_valid", longint'(y_valid), 1);
        repeat (2) tick();

        // Positive and negative saturation
        for (int k = 0; k < NB; k++) begin
            gain    = put(gain, k, 16'sd4096);
            band_in = put(band_in, k, 16'sd10000);
        end
        pulse();
        repeat (LAT + 1) tick();
        check("sat_pos", longint'($signed(y_out)), 32767);
        for (int k = 0; k < NB; k++) band_in = put(band_in, k, -16'sd10000);
        pulse();
        repeat (LAT + 1) tick();
        check("sat_neg", longint'($signed(y_out)), -32768);

        // Floor rounding with half gain; other bands carry noise at zero gain
        gain = put('0, 0, 16'sd2048);
        for (int k = 1; k < NB; k++) band_in = put(band_in, k, 16'($urandom));
        band_in = put(band_in, 0, -16'sd3);
        pulse();
        repeat (LAT + 1) tick();
        check("round_neg", longint'($signed(y_out)), -2);
        band_in = put(band_in, 0, 16'sd3);
        pulse();
        repeat (LAT + 1) tick();
        check("round_pos", longint'($signed(y_out)), 1);

        // Back-to-back strobes 17 cycles apart
        gain    = put('0, 0, 16'sd4096);
        band_in = put('0, 0, 16'sd777);
        pulse();
        repeat (16) tick();
        band_in = put('0, 0, -16'sd321);
        pulse();
        repeat (LAT + 1) tick();
        check("b2b_y_out", longint'($signed(y_out)), -321);
        check("b2b_overrun", longint'(overrun), 0);

        // Overrun with a gain change after acceptance
        gain    = put('0, 0, 16'sd4096);
        band_in = put('0, 0, 16'sd500);
        pulse();
        repeat (2) tick();
        gain = put(gain, 0, 16'sd8192);
        repeat (2) tick();
        pulse();
        repeat (LAT - 5) tick();
        check("snap_y_out", longint'($signed(y_out)), 500);
        check("ovr_set", longint'(overrun), 1);
        repeat (25) tick();
        check("ovr_sticky", longint'(overrun), 1);

        // Reset in the middle of MAC
        pulse();
        repeat (12) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_y_out", longint'(y_out), 0);
        check("midrst_y_valid", longint'(y_valid), 0);
        check("midrst_busy", longint'(busy), 0);
        check("midrst_overrun", longint'(overrun), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        cnt = 0;
        repeat (50) begin
            tick();
            if (y_valid) cnt++;
        end
        check("post_reset_valid_count", cnt, 0);

        // Strobe held high: starts on each idle cycle, flags overrun
        gain    = put('0, 1, 16'sd4096);
        band_in = put('0, 1, 16'sd1234);
        new_data = 1'b1;
        repeat (40) tick();
        new_data = 1'b0;
        repeat (LAT + 2) tick();
        check("held_overrun", longint'(overrun), 1);

        // Randomized traffic with live band changes every cycle
        for (int i = 0; i < 700; i++) begin
            for (int k = 0; k < NB; k++) begin
                band_in = put(band_in, k, 16'($urandom));
                if ($urandom_range(0, 15) == 0)
                    gain = put(gain, k, 16'($urandom_range(0, 16383) - 8192));
            end
            new_data = ($urandom_range(0, 19) == 0);
            tick();
        end
        new_data = 1'b0;
        repeat (LAT + 3) tick();
        check("scoreboard_drained", longint'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/eq_band_mixer.md
EQ_BAND_MIXER -- requirements
Module: eq_band_mixer

Interface
REQ-001 SHALL have parameter N_BAND, default 5: number of equalizer bands combined.
REQ-002 SHALL have parameter WAIT_CYCLES, default 10: clock cycles waited after new_data before band outputs are read (covers band-filter latency).
REQ-003 SHALL have parameter GAIN_FRAC, default 12: fractional bits of each gain (Q3.12, 4096 = unity).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port new_data, input, 1 bit: sample strobe, the same strobe that starts the band filters.
REQ-007 SHALL have port band_in, input, 16*N_BAND bits: packed signed band-filter outputs, band k in bits [16k+15:16k].
REQ-008 SHALL have port gain, input, 16*N_BAND bits: packed signed Q3.12 per-band gains, same packing as band_in.
REQ-009 SHALL have port y_out, output, 16 bits signed: mixed equalizer sample.
REQ-010 SHALL have port y_valid, output, 1 bit: one-cycle pulse when y_out updates.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag, set when new_data arrives while busy.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, MAC, OUT.
REQ-014 IDLE: on new_data=1, SHALL snapshot all gain words into internal registers, clear accumulator and counters, go to WAIT.
REQ-015 WAIT: SHALL stay exactly WAIT_CYCLES cycles, then go to MAC.
REQ-016 MAC: SHALL take exactly N_BAND cycles; cycle k adds band_in[k] * snapshot gain[k] (signed 16x16 = 32-bit) to the accumulator, then goes to OUT.
REQ-017 MAC: SHALL use one shared multiplier, time-multiplexed over bands.
REQ-018 MAC: SHALL sample band_in live during its cycle; band_in is not latched at new_data.
REQ-019 Accumulator SHALL be signed, at least 36 bits, and never overflow for N_BAND <= 8.
REQ-020 OUT: SHALL set y_out to accumulator arithmetic-shifted right by GAIN_FRAC (floor toward minus infinity).
REQ-021 OUT: SHALL saturate that result to [-32768, 32767].
REQ-022 OUT: SHALL assert y_valid for that one cycle, then return to IDLE.
REQ-023 Latency: with new_data sampled at edge 0, y_out/y_valid SHALL change at edge WAIT_CYCLES+N_BAND+1 (16 with defaults); throughput one sample per 17 cycles.
REQ-024 y_out SHALL hold its value between y_valid pulses.
REQ-025 y_valid SHALL be low in all states except the cycle following the OUT update.
REQ-026 new_data while busy (WAIT, MAC or OUT) SHALL be ignored and SHALL set overrun=1; the in-flight computation continues unaffected.
REQ-027 overrun SHALL clear only on reset.
REQ-028 new_data held high continuously SHALL start a new computation on the first IDLE cycle and set overrun on every busy cycle.
REQ-029 Gain changes after acceptance SHALL NOT affect the current sample.

Reset
REQ-030 While rst_n=0, asynchronously and regardless of state: state=IDLE, y_out=0, y_valid=0, busy=0, overrun=0, accumulator, counters and gain snapshot = 0.
REQ-031 Reset mid-operation SHALL abort the computation; no y_valid is produced for the aborted sample.
REQ-032 After release, the first new_data SHALL be accepted normally.

Verification
REQ-033 Reset check: assert rst_n=0 in the middle of MAC -> all outputs 0 immediately; after release and no new_data, y_valid stays 0 for 50 cycles.
REQ-034 Unity, single band: gain0=4096, other gains 0, band_in0=1000, new_data pulse at edge 0 -> y_out=1000 and y_valid=1 exactly after edge 16, busy high for 16 cycles.
REQ-035 Saturation: all gains 4096, all bands 10000 -> y_out=32767; all bands -10000 -> y_out=-32768.
REQ-036 Rounding: gain0=2048, band_in0=-3, others zero gain -> y_out=-2; band_in0=3 -> y_out=1.
REQ-037 Overrun and snapshot: second new_data at edge 5 and gain0 changed at edge 3 -> one y_valid only, result uses the original gain, overrun=1 until reset.
REQ-038 Back-to-back: new_data pulses at edges 0 and 17 -> two y_valid pulses at edges 16 and 33, overrun stays 0.
